upc_tag_tx: RTL
===============

// Module: upc_tag_tx
// PURPOSE
//  Checkout-side tag writer: takes an item UPC code {U,P,C} plus a "paid" flag and sends one
//  serial tag frame {U,P,C,M} to the exit-gate discount/stolen detector.
//  M (mark) = paid AND item is expensive; cheap items are never marked.
//  Sits between the checkout switch/scanner logic and the serial tag line.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per serial bit (>=2)
//  COUNT_W       8  width of frames_sent counter
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  in_valid    in   1        request: upc/paid valid
//  in_ready    out  1        block can accept a request
//  upc         in   3        item code {U,P,C}, U = upc[2]
//  paid        in   1        item paid at checkout
//  tx          out  1        serial tag line, idles high
//  busy        out  1        frame in progress
//  err         out  1        one-cycle pulse: nonexistent UPC rejected
//  frames_sent out  COUNT_W  frames transmitted, saturating
// BEHAVIOUR
//  - Reset (async, reset_n=0): tx=1, in_ready=1, busy=0, err=0, frames_sent=0, state IDLE,
//    bit timer and bit index cleared. Reset mid-frame aborts the frame immediately.
//  - Handshake: in_ready=1 only in IDLE. Accept when in_valid&&in_ready; latch upc and
//    computed M. in_ready drops on the next cycle.
//  - Valid codes: six. 3'b011 and 3'b111 do not exist. On acceptance of either: err=1 for
//    exactly the next cycle, no frame, frames_sent unchanged, stay IDLE (in_ready stays 1).
//  - expensive = ~P & (U | ~C); discounted = P | (U & C); M = paid & expensive.
//  - Frame, MSB first, each bit CLKS_PER_BIT cycles:
//    START(0), U, P, C, M, [PARITY], STOP(1).
//  - tx drives START the cycle after acceptance.
//  - FSM: IDLE -> START -> DATA (4 bits) -> PARITY (UPC_PARITY_EN only) -> STOP -> IDLE.
//    Each transition occurs on the last cycle of the bit timer.
//  - busy=1 from START through STOP inclusive.
//  - frames_sent increments on the final STOP cycle and holds at all-ones.
//  - Back-to-back: in_ready=1 the cycle after STOP ends. If in_valid is held, the next
//    START follows with no extra idle bit.
//  - Inputs change while busy: ignored; only latched values are sent.
// CONFIGURATION
//  UPC_PARITY_EN defined:
//    - even-parity bit (XOR of U,P,C,M) sent after M.
//    - frame = 7 bits = 7*CLKS_PER_BIT cycles.
//  UPC_PARITY_EN undefined:
//    - no parity state; STOP follows M.
//    - frame = 6 bits = 6*CLKS_PER_BIT cycles.
// STRUCTURE
//  upc_tag_pkg (shared with exit-gate detector):
//    - upc_t typedef
//    - tag_state_e enum
//    - UPC_INVALID_A/B constants
//    - DATA_BITS=4
//    - functions is_expensive(), is_discounted(), is_valid_upc()
//  Sub-module upc_bit_timer:
//    - counts 0..CLKS_PER_BIT-1 while enabled; pulses bit_done on the last count
//    - cleared by reset_n and on each handshake
// TESTING (CLKS_PER_BIT=4, UPC_PARITY_EN defined unless noted)
//  1 reset mid-frame: assert reset_n=0 during DATA
//    -> tx=1, busy=0, in_ready=1 in the same cycle; no frames_sent change
//  2 upc=3'b100, paid=1 -> M=1; tx sequence 0,1,0,0,1,0,1, 4 cycles each
//    -> frames_sent=1, busy high 28 cycles
//  3 upc=3'b001 (cheap), paid=1 -> M=0; sequence 0,0,0,1,0,1,1
//    -> never marked
//  4 upc=3'b011, in_valid=1 -> err pulse 1 cycle; tx stays 1, frames_sent=0
//  5 in_valid held with upc=3'b000, paid=0 for two frames
//    -> second START immediately follows first STOP; frames_sent=2
//  6 UPC_PARITY_EN undefined, upc=3'b100, paid=1 -> 0,1,0,0,1,1; busy high 24 cycles

Source files
------------

// File: rtl/upc_tag_pkg.sv
// upc_tag_pkg: types, constants and UPC classification helpers shared by the
// checkout tag writer and the exit-gate detector.
package upc_tag_pkg;

    typedef logic [2:0] upc_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tag_state_e;

    localparam upc_t UPC_INVALID_A = 3'b011;
    localparam upc_t UPC_INVALID_B = 3'b111;
    localparam int   DATA_BITS     = 4;

    // code = {U,P,C}
    function automatic logic is_expensive(input upc_t code);
        return ~code[1] & (code[2] | ~code[0]);
    endfunction

    function automatic logic is_discounted(input upc_t code);
        return code[1] | (code[2] & code[0]);
    endfunction

    function automatic logic is_valid_upc(input upc_t code);
        return (code != UPC_INVALID_A) && (code != UPC_INVALID_B);
    endfunction

endpackage

// File: rtl/upc_tag_tx_bit_timer.sv
// upc_bit_timer: divides the system clock into serial bit periods. Counts
// 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module upc_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_bitDone
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    assign o_bitDone = i_enable && (r_count == LAST_COUNT);

    // Bit-period counter; a handshake restarts it so START gets a full bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_bitDone ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/upc_tag_tx.sv
// upc_tag_tx: checkout-side tag writer. Accepts {U,P,C} plus a paid flag and
// sends one serial frame START,U,P,C,M,[PARITY],STOP (MSB first, tx idles high).
// Optional build macro: UPC_PARITY_EN adds an even-parity bit after M.
module upc_tag_tx
    import upc_tag_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int COUNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         upc,
    input  logic               paid,
    output logic               tx,
    output logic               busy,
    output logic               err,
    output logic [COUNT_W-1:0] frames_sent
);

`ifdef UPC_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);

    tag_state_e              r_state;
    tag_state_e              w_nextState;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [IDX_W-1:0]        r_bitIdx;
    logic                    r_err;
    logic [COUNT_W-1:0]      r_frames;

    logic                    w_accept;
    logic                    w_codeOk;
    logic                    w_mark;
    logic                    w_bitDone;
    logic                    w_stopDone;
    logic [FRAME_BITS-1:0]   w_frameWord;

    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_codeOk   = is_valid_upc(upc);
    assign w_mark     = paid & is_expensive(upc);
    assign w_stopDone = (r_state == ST_STOP) && w_bitDone;

`ifdef UPC_PARITY_EN
    assign w_frameWord = {1'b0, upc, w_mark, ^{upc, w_mark}, 1'b1};
`else
    assign w_frameWord = {1'b0, upc, w_mark, 1'b1};
`endif

    upc_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bitTimer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (r_state != ST_IDLE),
        .i_clear  (w_accept),
        .o_bitDone(w_bitDone)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and line outputs; transitions land on the last cycle of a bit.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        tx          = r_shift[FRAME_BITS-1];
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                tx       = 1'b1;
                if (w_accept && w_codeOk) begin
                    w_nextState = ST_START;
                end
            end
            ST_START: begin
                if (w_bitDone) begin
                    w_nextState = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bitDone && (r_bitIdx == LAST_DATA)) begin
`ifdef UPC_PARITY_EN
                    w_nextState = ST_PARITY;
`else
                    w_nextState = ST_STOP;
`endif
                end
            end
`ifdef UPC_PARITY_EN
            ST_PARITY: begin
                if (w_bitDone) begin
                    w_nextState = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bitDone) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Tracks which of the U,P,C,M bits is on the line during DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitIdx <= '0;
        end else if (r_state != ST_DATA) begin
            r_bitIdx <= '0;
        end else if (w_bitDone) begin
            r_bitIdx <= r_bitIdx + 1'b1;
        end
    end

    // Frame shift register: latched at acceptance, shifted out MSB first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '1;
        end else if (w_accept && w_codeOk) begin
            r_shift <= w_frameWord;
        end else if (w_bitDone) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b1};
        end
    end

    // One-cycle error pulse when a nonexistent code is handed over.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_codeOk;
        end
    end

    // Saturating count of completed frames, bumped as STOP finishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frames <= '0;
        end else if (w_stopDone && (r_frames != '1)) begin
            r_frames <= r_frames + 1'b1;
        end
    end

    assign err         = r_err;
    assign frames_sent = r_frames;

endmodule
